// File: rtl/data_memory_if.sv
// Load/store bus bundle for the data RAM.
// master drives a/wd/we and samples rd; slave is the memory side.
interface data_memory_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rd;
  logic [DATA_WIDTH-1:0] wd;
  logic [ADDR_WIDTH-1:0] a;
  logic                  we;

  modport master (
    output wd, a, we,
    input  rd
  );

  modport slave (
    input  wd, a, we,
    output rd
  );
endinterface

// File: rtl/data_memory.sv
// 64 x 32-bit word RAM: combinational read, synchronous write,
// async active-low reset clears every word.
// Ports (positional order fixed): RD read data, WD write data,
// A byte address (word = A[7:2]), WE write enable, clk, rst (active-low).
module data_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 2 ** (ADDR_WIDTH - 2)
) (
  output logic [DATA_WIDTH-1:0] RD,
  input  logic [DATA_WIDTH-1:0] WD,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  WE,
  input  logic                  clk,
  input  logic                  rst
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-3:0] widx;

  // Byte offset bits carry no meaning: no lanes, no trap.
  logic unused_lo;
  assign unused_lo = ^A[1:0];

  assign widx = A[ADDR_WIDTH-1:2];

  // No bypass: RD shows the stored word until the edge commits WD.
  assign RD = mem[widx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (WE) begin
      mem[widx] <= WD;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: directed plan plus random traffic
// against an array model; monitor checks RD at each falling edge.
module tb_data_memory;

  logic clk;
  logic rst;

  data_memory_if bus ();

  data_memory dut (
    .RD  (bus.rd),
    .WD  (bus.wd),
    .A   (bus.a),
    .WE  (bus.we),
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  a;
    string       name;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model [64];
  int          n_chk;
  int          n_pass;

  // Drive one cycle's inputs just after the rising edge, predict RD for
  // the coming falling edge, then commit the edge's effect to the model.
  task automatic cycle(input logic we, input logic [7:0] a,
                       input logic [31:0] wd, input logic r,
                       input string name);
    exp_t e;
    #1;
    rst    = r;
    bus.we = we;
    bus.a  = a;
    bus.wd = wd;
    if (!r) begin
      for (int i = 0; i < 64; i++) model[i] = '0;
    end
    e.d    = model[a / 4];
    e.a    = a;
    e.name = name;
    q.push_back(e);
    if (r && we) model[a / 4] = wd;
    @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if (bus.rd === e.d) begin
        n_pass++;
      end else begin
        $display("FAIL %s: A=%h RD=%h expected %h",
                 e.name, e.a, bus.rd, e.d);
      end
    end
  end

  initial begin
    logic [7:0] sweep [5];
    int         wait_n;
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b0;
    bus.we = 1'b0;
    bus.a  = '0;
    bus.wd = '0;
    for (int i = 0; i < 64; i++) model[i] = 32'hFFFF_FFFF;
    sweep[0] = 8'h00;
    sweep[1] = 8'h04;
    sweep[2] = 8'h08;
    sweep[3] = 8'hFC;
    sweep[4] = 8'h00;
    @(posedge clk);

    for (int i = 0; i < 5; i++)
      cycle(1'b1, sweep[i], 32'h5555_0000 + i, 1'b0, "rst_clear");

    cycle(1'b1, 8'h04, 32'h69, 1'b1, "wr_old");
    cycle(1'b0, 8'h00, 32'h0, 1'b1, "rd_w0");
    cycle(1'b0, 8'h04, 32'h0, 1'b1, "rd_w1");
    cycle(1'b1, 8'h08, 32'h70, 1'b1, "wr2_old");
    cycle(1'b0, 8'h08, 32'h0, 1'b1, "rd_w2");
    cycle(1'b0, 8'h04, 32'h0, 1'b1, "iso_w1");
    cycle(1'b0, 8'h00, 32'h0, 1'b1, "iso_w0");
    cycle(1'b0, 8'h05, 32'h0, 1'b1, "lowbit5");
    cycle(1'b0, 8'h07, 32'h0, 1'b1, "lowbit7");
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 8'h04, 32'hDEAD_BEEF, 1'b1, "no_write");
    cycle(1'b0, 8'h04, 32'h0, 1'b1, "no_write_after");
    cycle(1'b1, 8'hFC, 32'hFFFF_FFFF, 1'b1, "top_wr1");
    cycle(1'b1, 8'hFC, 32'h1234_5678, 1'b1, "top_wr2");
    cycle(1'b0, 8'hFC, 32'h0, 1'b1, "top_rd");
    cycle(1'b0, 8'h00, 32'h0, 1'b1, "top_iso");

    cycle(1'b0, 8'h04, 32'h0, 1'b0, "mid_rst_w1");
    cycle(1'b0, 8'hFC, 32'h0, 1'b0, "mid_rst_w63");
    cycle(1'b1, 8'h04, 32'hAA, 1'b0, "rst_blocks_wr");
    cycle(1'b0, 8'h04, 32'h0, 1'b1, "after_rel_w1");
    cycle(1'b0, 8'h08, 32'h0, 1'b1, "after_rel_w2");

    for (int i = 0; i < 300; i++) begin
      logic       we;
      logic       r;
      logic [7:0] a;
      we = ($urandom_range(0, 1) == 1);
      r  = ($urandom_range(0, 49) != 0);
      // Bias addresses into a few words so reads hit recent writes.
      if ($urandom_range(0, 1) == 1)
        a = 8'($urandom_range(0, 15));
      else
        a = 8'($urandom);
      cycle(we, a, $urandom, r, "random");
    end

    wait_n = 0;
    while (q.size() > 0 && wait_n < 10) begin
      @(posedge clk);
      wait_n++;
    end
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: pending=%0d expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
